// File: rtl/reg_file_sb_if.sv
// rtl/reg_file_sb_if.sv - decode/writeback bus of the scoreboarded register file
interface reg_file_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              rd_busy_a;
    logic              rd_busy_b;
    logic              wr0_en;
    logic [ADDR_W-1:0] wr0_addr;
    logic [DATA_W-1:0] wr0_data;
    logic              wr1_en;
    logic [ADDR_W-1:0] wr1_addr;
    logic [DATA_W-1:0] wr1_data;
    logic              rsv_en;
    logic [ADDR_W-1:0] rsv_addr;
    logic              rsv_ok;
    logic [ADDR_W:0]   busy_count;
    logic [DATA_W-1:0] register_v0;

    // Pipeline side: decode issues reads and reservations, writeback issues writes
    modport master (
        output rd_addr_a, rd_addr_b, wr0_en, wr0_addr, wr0_data,
               wr1_en, wr1_addr, wr1_data, rsv_en, rsv_addr,
        input  rd_data_a, rd_data_b, rd_busy_a, rd_busy_b,
               rsv_ok, busy_count, register_v0
    );

    // Register file side
    modport slave (
        input  rd_addr_a, rd_addr_b, wr0_en, wr0_addr, wr0_data,
               wr1_en, wr1_addr, wr1_data, rsv_en, rsv_addr,
        output rd_data_a, rd_data_b, rd_busy_a, rd_busy_b,
               rsv_ok, busy_count, register_v0
    );
endinterface

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - scoreboarded GPR file, 2 read / 2 write ports, optional REG_FILE_BYPASS_EN write-to-read bypass
module reg_file_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int V0_IDX = 2
) (
    input logic          clk,
    input logic          reset,
    reg_file_sb_if.slave bus
);
    localparam int NREGS = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W + 1)'(NREGS - 1);

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  busy;
    logic [ADDR_W:0]   count;

    logic wr1_hits_rsv;
    logic rsv_ok;
    logic set_busy;
    logic clr_busy;
    logic cnt_inc;
    logic cnt_dec;

    // Reservation acceptance and scoreboard set/clear decisions for this cycle
    always_comb begin
        wr1_hits_rsv = bus.wr1_en && (bus.wr1_addr == bus.rsv_addr);
        // busy[0] is never set, so a reserve of r0 is always accepted and ignored
        rsv_ok       = bus.rsv_en && (!busy[bus.rsv_addr] || wr1_hits_rsv);
        set_busy     = rsv_ok && (bus.rsv_addr != '0);
        clr_busy     = bus.wr1_en && (bus.wr1_addr != '0) && busy[bus.wr1_addr];
        cnt_inc      = set_busy && !busy[bus.rsv_addr];
        // a release of the register being re-reserved leaves it busy: no decrement
        cnt_dec      = clr_busy && !(set_busy && wr1_hits_rsv);
    end

    // Read ports: stored value, optionally overridden by same-cycle writes, r0 forced to zero
    always_comb begin
        bus.rd_data_a = regs[bus.rd_addr_a];
        bus.rd_data_b = regs[bus.rd_addr_b];
        bus.rd_busy_a = busy[bus.rd_addr_a];
        bus.rd_busy_b = busy[bus.rd_addr_b];
`ifdef REG_FILE_BYPASS_EN
        if (!reset) begin
            if (bus.wr1_en && (bus.wr1_addr == bus.rd_addr_a)) begin
                bus.rd_data_a = bus.wr1_data;
                bus.rd_busy_a = 1'b0;
            end
            if (bus.wr1_en && (bus.wr1_addr == bus.rd_addr_b)) begin
                bus.rd_data_b = bus.wr1_data;
                bus.rd_busy_b = 1'b0;
            end
            // wr0 is the younger instruction, so it overrides wr1
            if (bus.wr0_en && (bus.wr0_addr == bus.rd_addr_a)) begin
                bus.rd_data_a = bus.wr0_data;
            end
            if (bus.wr0_en && (bus.wr0_addr == bus.rd_addr_b)) begin
                bus.rd_data_b = bus.wr0_data;
            end
        end
`endif
        if (bus.rd_addr_a == '0) begin
            bus.rd_data_a = '0;
            bus.rd_busy_a = 1'b0;
        end
        if (bus.rd_addr_b == '0) begin
            bus.rd_data_b = '0;
            bus.rd_busy_b = 1'b0;
        end
    end

    assign bus.rsv_ok      = rsv_ok;
    assign bus.busy_count  = count;
    assign bus.register_v0 = regs[V0_IDX];

    // Register writes, busy bits and reserved-register count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            busy  <= '0;
            count <= '0;
        end else begin
            if (bus.wr1_en && (bus.wr1_addr != '0)) begin
                regs[bus.wr1_addr] <= bus.wr1_data;
            end
            // later assignment wins: wr0 takes a same-address collision
            if (bus.wr0_en && (bus.wr0_addr != '0)) begin
                regs[bus.wr0_addr] <= bus.wr0_data;
            end
            if (clr_busy) begin
                busy[bus.wr1_addr] <= 1'b0;
            end
            // set after clear so a same-register reserve keeps the bit high
            if (set_busy) begin
                busy[bus.rsv_addr] <= 1'b1;
            end
            if (cnt_inc && !cnt_dec && (count != CNT_MAX)) begin
                count <= count + 1'b1;
            end else if (cnt_dec && !cnt_inc && (count != '0)) begin
                count <= count - 1'b1;
            end
        end
    end
endmodule
